// File: rtl/dmem_sized_access.sv
// dmem_sized_access: little-endian data memory for the pipelined MIPS datapath.
// Byte/halfword/word loads and stores behind a req/accept/ready handshake with
// LATENCY wait states. Misaligned, reserved-size and out-of-range accesses
// complete with err=1 and leave memory untouched.
// Optional build macro DMEM_DEBUG_PORT_EN adds a combinational word read port
// (dbg_addr/dbg_data) that does not interact with the handshake.
module dmem_sized_access #(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int LATENCY    = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req,
  input  logic                      we,
  input  logic [1:0]                size,
  input  logic                      unsigned_ld,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [31:0]               wdata,
  output logic                      accept,
  output logic                      ready,
  output logic [31:0]               rdata,
  output logic                      err
`ifdef DMEM_DEBUG_PORT_EN
  ,
  input  logic [$clog2(DEPTH)-1:0]  dbg_addr,
  output logic [31:0]               dbg_data
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] LAT4 = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q;
  logic                    we_q, uns_q;
  logic [1:0]              size_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic [31:0]             mem [DEPTH];

  logic                    take;
  logic                    access;
  logic [IDX_W-1:0]        idx;
  logic                    out_of_range;
  logic                    acc_err;
  logic [3:0]              be;
  logic [31:0]             wr_word;
  logic [31:0]             rd_word;
  logic [7:0]              ld_byte;
  logic [15:0]             ld_half;
  logic [31:0]             load_val;

  assign accept = (state_q == IDLE) || (state_q == DONE);
  assign take   = req && accept;
  assign access = (state_q == BUSY) && (cnt_q == 4'd0);

  // Next-state logic: DONE is a single ready cycle that can chain straight into the next access
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = BUSY;
      BUSY:    if (cnt_q == 4'd0) state_d = DONE;
      DONE:    state_d = req ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and wait-state counter; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      if (take)
        cnt_q <= LAT4;
      else if (state_q == BUSY && cnt_q != 4'd0)
        cnt_q <= cnt_q - 4'd1;
    end
  end

  // Capture the request fields so the inputs are free to change while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
    end else if (take) begin
      we_q    <= we;
      size_q  <= size;
      uns_q   <= unsigned_ld;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // Address decode and error classification of the captured access
  always_comb begin
    idx          = addr_q[IDX_W+1:2];
    out_of_range = |addr_q[ADDR_WIDTH-1:IDX_W+2];
    acc_err      = out_of_range;
    case (size_q)
      2'b01:   if (addr_q[0]) acc_err = 1'b1;
      2'b10:   if (addr_q[1:0] != 2'b00) acc_err = 1'b1;
      2'b11:   acc_err = 1'b1;
      default: ;
    endcase
  end

  // Store lane enables with the store data replicated onto every lane it may target
  always_comb begin
    be      = 4'b0000;
    wr_word = wdata_q;
    case (size_q)
      2'b00: begin
        be[addr_q[1:0]] = 1'b1;
        wr_word         = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be      = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wdata_q[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Load lane selection and sign/zero extension of sub-word results
  always_comb begin
    rd_word = mem[idx];
    case (addr_q[1:0])
      2'b00:   ld_byte = rd_word[7:0];
      2'b01:   ld_byte = rd_word[15:8];
      2'b10:   ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    ld_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (size_q)
      2'b00:   load_val = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   load_val = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: load_val = rd_word;
    endcase
  end

  // Memory array: cleared by reset, byte-lane writes only for legal stores
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= 32'd0;
    end else if (access && we_q && !acc_err) begin
      for (int l = 0; l < 4; l++)
        if (be[l])
          mem[idx][8*l +: 8] <= wr_word[8*l +: 8];
    end
  end

  // Response registers: ready/err/rdata are only nonzero in the DONE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= 32'd0;
    end else begin
      ready <= access;
      err   <= access && acc_err;
      rdata <= (access && !we_q && !acc_err) ? load_val : 32'd0;
    end
  end

`ifdef DMEM_DEBUG_PORT_EN
  assign dbg_data = mem[dbg_addr];
`endif

endmodule
